// File: rtl/fifo_burst_reader_if.sv
// -----------------------------------------------------------------------------
// fifo_burst_reader_if
//   Valid/ready word stream produced by fifo_burst_reader.
//
//   M_VALID  master -> slave   word on M_DATA/M_LAST is valid
//   M_READY  slave  -> master  downstream accepts the word this cycle
//   M_DATA   master -> slave   data word (WIDTH bits)
//   M_LAST   master -> slave   final word of the burst, qualified by M_VALID
// -----------------------------------------------------------------------------
interface fifo_burst_reader_if #(
  parameter int WIDTH = 8
);
  logic             M_VALID;
  logic             M_READY;
  logic [WIDTH-1:0] M_DATA;
  logic             M_LAST;

  modport master (output M_VALID, M_DATA, M_LAST, input  M_READY);
  modport slave  (input  M_VALID, M_DATA, M_LAST, output M_READY);
endinterface

// File: rtl/fifo_burst_reader.sv
// -----------------------------------------------------------------------------
// fifo_burst_reader
//   Read-side engine for first-word-fall-through FIFOs. On START it pops LEN
//   words from the FIFO read port and hands them downstream on a valid/ready
//   stream, tagging the final word with M_LAST. A 2-entry output buffer keeps
//   the FIFO pop independent of downstream backpressure: REN never depends on
//   M_READY, only on registered state and EMPTY.
//
//   Ports
//     CLK       clock, rising edge
//     RST       asynchronous active-high reset
//     START     one-cycle burst request, sampled only while idle
//     LEN       burst length in words, latched when START is accepted
//     EMPTY     FIFO empty flag
//     R_DO      FIFO head word (valid while EMPTY=0)
//     REN       FIFO pop; head consumed at the edge where REN=1
//     m         output stream (master modport of fifo_burst_reader_if)
//     BUSY      high whenever a burst is in progress
//     DONE      one-cycle pulse after a burst completes
//     WORD_CNT  words handed off downstream in the current burst
// -----------------------------------------------------------------------------
module fifo_burst_reader #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 16
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 START,
  input  logic [CNT_W-1:0]     LEN,
  input  logic                 EMPTY,
  input  logic [WIDTH-1:0]     R_DO,
  output logic                 REN,
  fifo_burst_reader_if.master  m,
  output logic                 BUSY,
  output logic                 DONE,
  output logic [CNT_W-1:0]     WORD_CNT
);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    FLUSH
  } state_t;

  state_t           state;
  state_t           state_nxt;

  logic [CNT_W-1:0] rem;          // words still to pop in this burst
  logic [CNT_W-1:0] word_cnt;
  logic             done_q;

  // Output buffer: two {data, last} entries addressed as a tiny ring.
  logic [WIDTH-1:0] buf_data [2];
  logic             buf_last [2];
  logic             wr_ptr;
  logic             rd_ptr;
  logic [1:0]       occ;

  logic             out_valid;
  logic             head_last;
  logic             push;
  logic             pop;
  logic             start_burst;
  logic             done_set;

  assign out_valid = (occ != 2'd0);
  assign head_last = buf_last[rd_ptr];
  assign pop       = out_valid & m.M_READY;
  assign push      = REN;

  assign m.M_VALID = out_valid;
  assign m.M_DATA  = buf_data[rd_ptr];
  assign m.M_LAST  = head_last;

  assign DONE      = done_q;
  assign WORD_CNT  = word_cnt;

  // ---------------------------------------------------------------------------
  // Next-state and control decode
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path
    // through the case statement can leave a value unassigned and infer a latch.
    state_nxt   = state;
    REN         = 1'b0;
    BUSY        = (state != IDLE);
    start_burst = 1'b0;
    done_set    = 1'b0;

    case (state)
      IDLE: begin
        if (START) begin
          if (LEN != '0) begin
            start_burst = 1'b1;
            state_nxt   = RUN;
          end else begin
            // Zero-length request completes without touching the FIFO.
            done_set = 1'b1;
          end
        end
      end

      RUN: begin
        REN = !EMPTY && (rem != '0) && (occ < 2'd2);
        if (REN && (rem == CNT_W'(1))) begin
          state_nxt = FLUSH;
        end
      end

      FLUSH: begin
        // The last-tagged word is always the newest entry, so its handoff
        // also empties the buffer.
        if (pop && head_last) begin
          state_nxt = IDLE;
          done_set  = 1'b1;
        end
      end

      default: state_nxt = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  always_ff @(posedge CLK or posedge RST) begin
    // NOTE: registers use non-blocking assignments so every flop samples the
    // pre-edge values regardless of statement or process ordering.
    if (RST) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // ---------------------------------------------------------------------------
  // Burst counters and completion pulse
  // ---------------------------------------------------------------------------
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      rem      <= '0;
      word_cnt <= '0;
      done_q   <= 1'b0;
    end else begin
      done_q <= done_set;
      if (start_burst) begin
        rem      <= LEN;
        word_cnt <= '0;
      end else begin
        if (push) rem      <= rem - CNT_W'(1);
        if (pop)  word_cnt <= word_cnt + CNT_W'(1);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Output buffer
  // ---------------------------------------------------------------------------
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      // NOTE: the buffer storage is reset as well because M_DATA/M_LAST read
      // the head entry directly and must show zero after reset; with only two
      // entries this costs nothing meaningful.
      for (int i = 0; i < 2; i++) begin
        buf_data[i] <= '0;
        buf_last[i] <= 1'b0;
      end
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      occ    <= 2'd0;
    end else begin
      if (push) begin
        buf_data[wr_ptr] <= R_DO;
        buf_last[wr_ptr] <= (rem == CNT_W'(1));
        wr_ptr           <= ~wr_ptr;
      end
      if (pop) begin
        rd_ptr <= ~rd_ptr;
      end
      case ({push, pop})
        2'b10:   occ <= occ + 2'd1;
        2'b01:   occ <= occ - 2'd1;
        default: occ <= occ;
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_burst_reader.sv
// -----------------------------------------------------------------------------
// tb_fifo_burst_reader
//   Scoreboard bench for fifo_burst_reader. Each burst request pushes its
//   words into a behavioural FWFT FIFO and the expected {data, last, index}
//   stream into a queue; a monitor process pops and compares on every
//   downstream handoff, and also watches REN against EMPTY, stall stability
//   and DONE/BUSY/WORD_CNT at completion.
// -----------------------------------------------------------------------------
module tb_fifo_burst_reader;

  localparam int WIDTH = 8;
  localparam int CNT_W = 16;

  typedef struct {
    logic [WIDTH-1:0] data;
    logic             last;
    int               idx;
  } exp_t;

  logic             CLK = 1'b0;
  logic             RST;
  logic             START;
  logic [CNT_W-1:0] LEN;
  logic             EMPTY;
  logic [WIDTH-1:0] R_DO;
  logic             REN;
  logic             BUSY;
  logic             DONE;
  logic [CNT_W-1:0] WORD_CNT;

  fifo_burst_reader_if #(.WIDTH(WIDTH)) bus ();

  fifo_burst_reader #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .CLK      (CLK),
    .RST      (RST),
    .START    (START),
    .LEN      (LEN),
    .EMPTY    (EMPTY),
    .R_DO     (R_DO),
    .REN      (REN),
    .m        (bus.master),
    .BUSY     (BUSY),
    .DONE     (DONE),
    .WORD_CNT (WORD_CNT)
  );

  always #5 CLK = ~CLK;

  int checks   = 0;
  int failures = 0;

  logic [WIDTH-1:0] src_q [$];   // behavioural FIFO contents
  exp_t             exp_q [$];   // expected downstream words
  int               done_q [$];  // expected WORD_CNT at each DONE (-1: skip)
  int               hs_cyc [$];  // cycle number of every handoff

  int ready_mode = 0;            // 0: always ready, 1: held low, 2: random
  bit starve     = 1'b0;         // EMPTY forced high every other cycle
  bit phase      = 1'b0;
  int pop_cnt    = 0;
  int hs_cnt     = 0;
  int cyc        = 0;
  int done_cyc   = 0;

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // FIFO model and downstream ready driver
  // ---------------------------------------------------------------------------
  initial begin
    bit pop_pending;
    EMPTY       = 1'b1;
    R_DO        = '0;
    bus.M_READY = 1'b0;
    forever begin
      @(negedge CLK);
      pop_pending = REN;
      @(posedge CLK);
      #1;
      if (RST) pop_pending = 1'b0;
      if (pop_pending && src_q.size() != 0) begin
        void'(src_q.pop_front());
        pop_cnt++;
      end
      phase = ~phase;
      case (ready_mode)
        0:       bus.M_READY = 1'b1;
        1:       bus.M_READY = 1'b0;
        default: bus.M_READY = ($urandom_range(99) < 60);
      endcase
      EMPTY = (src_q.size() == 0) || (starve && phase);
      R_DO  = (src_q.size() != 0) ? src_q[0] : '0;
    end
  end

  // ---------------------------------------------------------------------------
  // Monitor / scoreboard
  // ---------------------------------------------------------------------------
  logic             hold_prev = 1'b0;
  logic [WIDTH-1:0] prev_data;
  logic             prev_last;

  always @(negedge CLK) begin
    if (RST) begin
      hold_prev = 1'b0;
    end else begin
      cyc++;
      if (REN) check("ren_while_empty", EMPTY, 0);
      if (hold_prev) begin
        check("stall_valid", bus.M_VALID, 1);
        check("stall_data", bus.M_DATA, prev_data);
        check("stall_last", bus.M_LAST, prev_last);
      end
      if (bus.M_VALID && bus.M_READY) begin
        check("word_expected", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) begin
          exp_t e;
          e = exp_q.pop_front();
          check("m_data", bus.M_DATA, e.data);
          check("m_last", bus.M_LAST, e.last);
          check("word_cnt", WORD_CNT, e.idx);
        end
        hs_cnt++;
        hs_cyc.push_back(cyc);
      end
      if (DONE) begin
        check("done_busy", BUSY, 0);
        check("done_expected", done_q.size() != 0, 1);
        if (done_q.size() != 0) begin
          int wc;
          wc = done_q.pop_front();
          if (wc >= 0) check("done_word_cnt", WORD_CNT, wc);
        end
        done_cyc = cyc;
      end
      hold_prev = bus.M_VALID && !bus.M_READY;
      prev_data = bus.M_DATA;
      prev_last = bus.M_LAST;
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus helpers
  // ---------------------------------------------------------------------------
  // Queue a burst: FIFO contents plus the stream and completion it must produce.
  task automatic load_burst(input int len, input int base);
    for (int i = 0; i < len; i++) begin
      logic [WIDTH-1:0] d;
      d = (base >= 0) ? WIDTH'(base + i) : WIDTH'($urandom);
      src_q.push_back(d);
      exp_q.push_back('{data: d, last: (i == len - 1), idx: i});
    end
    done_q.push_back((len == 0) ? -1 : len);
  endtask

  task automatic pulse_start(input int len);
    START = 1'b1;
    LEN   = CNT_W'(len);
    @(negedge CLK);
    START = 1'b0;
    check("busy_after_start", BUSY, len != 0);
  endtask

  task automatic wait_done(input int budget);
    int n = 0;
    do begin
      @(negedge CLK);
      n++;
    end while (!DONE && n < budget);
    check("done_seen", DONE, 1);
    #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_ren"},      REN, 0);
    check({tag, "_m_valid"},  bus.M_VALID, 0);
    check({tag, "_m_data"},   bus.M_DATA, 0);
    check({tag, "_m_last"},   bus.M_LAST, 0);
    check({tag, "_busy"},     BUSY, 0);
    check({tag, "_done"},     DONE, 0);
    check({tag, "_word_cnt"}, WORD_CNT, 0);
  endtask

  // ---------------------------------------------------------------------------
  // Test sequence
  // ---------------------------------------------------------------------------
  initial begin
    int pc0;
    int h0;
    int n;

    RST   = 1'b1;
    START = 1'b0;
    LEN   = '0;
    repeat (3) @(negedge CLK);
    check_reset_outputs("reset");
    RST = 1'b0;
    @(negedge CLK);

    // Burst with no stalls: four back-to-back words, DONE one cycle later.
    ready_mode = 0;
    @(negedge CLK);
    load_burst(4, 'h10);
    pc0 = pop_cnt;
    pulse_start(4);
    wait_done(50);
    check("nostall_pops", pop_cnt - pc0, 4);
    check("nostall_span", hs_cyc[hs_cyc.size() - 1] - hs_cyc[hs_cyc.size() - 4], 3);
    check("nostall_done_lat", done_cyc - hs_cyc[hs_cyc.size() - 1], 1);

    // Backpressure: only two pops while downstream stalls.
    ready_mode = 1;
    @(negedge CLK);
    load_burst(6, -1);
    pc0 = pop_cnt;
    pulse_start(6);
    repeat (5) @(negedge CLK);
    check("stall_pops", pop_cnt - pc0, 2);
    ready_mode = 0;
    wait_done(100);
    check("stall_total_pops", pop_cnt - pc0, 6);

    // Starved FIFO: EMPTY toggles every cycle.
    starve = 1'b1;
    load_burst(3, -1);
    pulse_start(3);
    wait_done(100);
    starve = 1'b0;

    // Zero-length request.
    load_burst(0, -1);
    pc0 = pop_cnt;
    pulse_start(0);
    check("len0_done", DONE, 1);
    @(negedge CLK);
    check("len0_done_once", DONE, 0);
    check("len0_busy", BUSY, 0);
    check("len0_pops", pop_cnt - pc0, 0);

    // START during a burst is ignored; extra FIFO words must stay unread.
    ready_mode = 2;
    load_burst(5, -1);
    for (int i = 0; i < 4; i++) src_q.push_back(WIDTH'($urandom));
    pc0 = pop_cnt;
    pulse_start(5);
    @(negedge CLK);
    START = 1'b1;
    LEN   = CNT_W'(3);
    @(negedge CLK);
    START = 1'b0;
    wait_done(200);
    check("ignored_start_pops", pop_cnt - pc0, 5);
    src_q.delete();
    @(negedge CLK);

    // Reset mid-burst after two deliveries.
    load_burst(8, -1);
    h0 = hs_cnt;
    pulse_start(8);
    n = 0;
    while (hs_cnt < h0 + 2 && n < 200) begin
      @(negedge CLK);
      #1;
      n++;
    end
    check("reset_mid_reached", hs_cnt - h0, 2);
    RST = 1'b1;
    src_q.delete();
    exp_q.delete();
    done_q.delete();
    #1;
    check_reset_outputs("mid_reset");
    repeat (2) @(negedge CLK);
    check_reset_outputs("mid_reset_hold");
    RST = 1'b0;
    @(negedge CLK);
    @(negedge CLK);
    load_burst(2, -1);
    pulse_start(2);
    wait_done(100);

    // Back-to-back bursts, second START in the DONE cycle.
    ready_mode = 0;
    @(negedge CLK);
    load_burst(2, -1);
    load_burst(2, -1);
    pulse_start(2);
    wait_done(50);
    pulse_start(2);
    wait_done(50);

    // Randomized bursts.
    for (int b = 0; b < 20; b++) begin
      int len;
      len        = $urandom_range(1, 12);
      ready_mode = ($urandom_range(3) == 0) ? 0 : 2;
      starve     = $urandom_range(1);
      load_burst(len, -1);
      pulse_start(len);
      wait_done(600);
    end
    starve = 1'b0;
    repeat (3) @(negedge CLK);

    check("exp_drained", exp_q.size(), 0);
    check("done_drained", done_q.size(), 0);
    check("fifo_drained", src_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
